oam_dma_engine: RTL and testbench

- Bus initiator for the SM83 memory model.
- When the CPU writes the DMA register, it copies a block of LENGTH bytes from {src_hi, 8'h00} to DST_BASE.
- It drives the r_addr/r_data/w_addr/w_data/wen interface of a combinational-read, synchronous-write memory, one byte per CYCLES_PER_BYTE clocks.
- It sits beside the CPU core and asserts busy so the bus arbiter blocks CPU accesses.

---
 rtl/sm83_pkg.sv | 28 ++
 rtl/oam_dma_engine.sv | 165 ++++++++++++++++
 tb/tb_oam_dma_engine.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sm83_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sm83_pkg
// Description : Shared types and constants for the SM83 memory model,
//               including the OAM DMA engine state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package sm83_pkg;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;

  // DMA engine sequencing states
  typedef enum logic [2:0] {
    DMA_IDLE  = 3'd0,
    DMA_DELAY = 3'd1,
    DMA_READ  = 3'd2,
    DMA_WRITE = 3'd3,
    DMA_GAP   = 3'd4
  } dma_state_t;

  localparam addr_t OAM_BASE     = 16'hFE00;
  localparam int    OAM_DMA_LEN  = 160;
  // Address the external decoder matches to raise reg_wen
  localparam addr_t DMA_REG_ADDR = 16'hFF46;

endpackage
`default_nettype wire

// File: rtl/oam_dma_engine.sv
`default_nettype none
// ============================================================================
// Module      : oam_dma_engine
// Description : OAM DMA bus initiator. A CPU write to the DMA register copies
//               LENGTH bytes from {src_hi,8'h00} to DST_BASE, one byte per
//               CYCLES_PER_BYTE clocks, holding busy for the whole transfer.
//               Optional macro OAM_DMA_ECHO_FOLD_EN folds echo-RAM source
//               pages E0..FF down by 8'h20 when the register is latched.
// Revision    : 1.0 - initial release
// ============================================================================
module oam_dma_engine
  import sm83_pkg::*;
#(
  parameter int    LENGTH          = OAM_DMA_LEN,
  parameter int    CYCLES_PER_BYTE = 4,
  parameter int    START_DELAY     = 4,
  parameter addr_t DST_BASE        = OAM_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_wen,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  reg_rdata,
  output addr_t       mem_r_addr,
  input  data_t       mem_r_data,
  output addr_t       mem_w_addr,
  output data_t       mem_w_data,
  output logic        mem_wen,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] c_delay_load = 16'(START_DELAY - 1);
  localparam logic [15:0] c_gap_load   = 16'((CYCLES_PER_BYTE > 2) ? (CYCLES_PER_BYTE - 3) : 0);
  localparam logic        c_has_gap    = (CYCLES_PER_BYTE > 2);
  localparam logic [7:0]  c_last_idx   = 8'(LENGTH - 1);

  dma_state_t  r_state;
  dma_state_t  w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic [7:0]  r_idx;
  logic [7:0]  w_idx_nxt;
  logic [7:0]  r_src_hi;
  logic [7:0]  r_reg;
  data_t       r_data;
  logic        r_done;
  logic        w_done_nxt;
  logic        w_slot_end;
  logic [7:0]  w_src_fold;

`ifdef OAM_DMA_ECHO_FOLD_EN
  // Echo RAM E000..FFFF mirrors C000..DFFF; read from the real page instead
  assign w_src_fold = (reg_wdata >= 8'hE0) ? (reg_wdata - 8'h20) : reg_wdata;
`else
  assign w_src_fold = reg_wdata;
`endif

  // State, shared slot/delay down-counter, byte index and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= DMA_IDLE;
      r_cnt   <= 16'd0;
      r_idx   <= 8'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state sequencing; a register write restarts from any state
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;
    w_slot_end  = 1'b0;
    case (r_state)
      DMA_IDLE: begin
        w_state_nxt = DMA_IDLE;
      end
      DMA_DELAY: begin
        if (r_cnt == 16'd0) begin
          w_state_nxt = DMA_READ;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      DMA_READ: begin
        w_state_nxt = DMA_WRITE;
      end
      DMA_WRITE: begin
        if (c_has_gap) begin
          w_state_nxt = DMA_GAP;
          w_cnt_nxt   = c_gap_load;
        end else begin
          w_slot_end = 1'b1;
        end
      end
      DMA_GAP: begin
        if (r_cnt == 16'd0) begin
          w_slot_end = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      default: begin
        w_state_nxt = DMA_IDLE;
      end
    endcase

    if (w_slot_end) begin
      if (r_idx == c_last_idx) begin
        w_state_nxt = DMA_IDLE;
        w_done_nxt  = 1'b1;
      end else begin
        w_idx_nxt   = r_idx + 8'd1;
        w_state_nxt = DMA_READ;
      end
    end

    if (reg_wen) begin
      w_state_nxt = DMA_DELAY;
      w_cnt_nxt   = c_delay_load;
      w_idx_nxt   = 8'd0;
      w_done_nxt  = 1'b0;
    end
  end

  // DMA register: the source page used internally and the value read back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src_hi <= 8'h00;
      r_reg    <= 8'h00;
    end else if (reg_wen) begin
      r_src_hi <= w_src_fold;
      r_reg    <= reg_wdata;
    end
  end

  // Capture the source byte at the end of its READ cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= 8'h00;
    end else if (r_state == DMA_READ) begin
      r_data <= mem_r_data;
    end
  end

  // Bus outputs are decoded purely from registered state
  always_comb begin
    reg_rdata  = r_reg;
    busy       = (r_state != DMA_IDLE);
    done       = r_done;
    mem_wen    = (r_state == DMA_WRITE);
    mem_r_addr = (r_state == DMA_READ) ? {r_src_hi, r_idx} : 16'h0000;
    mem_w_addr = (r_state == DMA_WRITE) ? (DST_BASE + {8'h00, r_idx}) : 16'h0000;
    mem_w_data = (r_state == DMA_WRITE) ? r_data : 8'h00;
  end

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_oam_dma_engine
// Description : Self-checking bench for oam_dma_engine with a behavioural
//               combinational-read / synchronous-write memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oam_dma_engine;
  import sm83_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reg_wen = 1'b0;
  logic [7:0]  reg_wdata = 8'h00;
  logic [7:0]  reg_rdata;
  addr_t       mem_r_addr, mem_w_addr;
  data_t       mem_r_data, mem_w_data;
  logic        mem_wen, busy, done;

  logic        s2_wen = 1'b0;
  logic [7:0]  s2_wdata = 8'h00;
  logic [7:0]  s2_rdata;
  addr_t       s2_r_addr, s2_w_addr;
  data_t       s2_r_data, s2_w_data;
  logic        s2_mwen, s2_busy, s2_done;

  logic [7:0]  mem  [0:65535];
  logic [7:0]  mem2 [0:65535];
  logic        pre_we = 1'b0, pre2_we = 1'b0;
  logic [15:0] pre_addr = 16'h0;
  logic [7:0]  pre_data = 8'h0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  oam_dma_engine u_dut (
    .clk(clk), .rst(rst), .reg_wen(reg_wen), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
    .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data), .mem_wen(mem_wen),
    .busy(busy), .done(done)
  );

  oam_dma_engine #(.LENGTH(1), .CYCLES_PER_BYTE(2), .START_DELAY(4), .DST_BASE(16'hFE00)) u_dut2 (
    .clk(clk), .rst(rst), .reg_wen(s2_wen), .reg_wdata(s2_wdata),
    .reg_rdata(s2_rdata), .mem_r_addr(s2_r_addr), .mem_r_data(s2_r_data),
    .mem_w_addr(s2_w_addr), .mem_w_data(s2_w_data), .mem_wen(s2_mwen),
    .busy(s2_busy), .done(s2_done)
  );

  assign mem_r_data = mem[mem_r_addr];
  assign s2_r_data  = mem2[s2_r_addr];

  always @(posedge clk) begin
    if (mem_wen) mem[mem_w_addr] <= mem_w_data;
    if (pre_we)  mem[pre_addr]   <= pre_data;
    if (s2_mwen) mem2[s2_w_addr] <= s2_w_data;
    if (pre2_we) mem2[pre_addr]  <= pre_data;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // mode 0: i^5A, 1: ~i, 2: zero
  task automatic fill(input logic [15:0] base, input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pre_we   = 1'b1;
      pre_addr = base + 16'(i);
      pre_data = (mode == 0) ? (8'(i) ^ 8'h5A) : (mode == 1) ? ~8'(i) : 8'h00;
    end
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic write_reg(input logic [7:0] v);
    @(negedge clk); reg_wen = 1'b1; reg_wdata = v;
    @(negedge clk); reg_wen = 1'b0;
  endtask

  task automatic count_bad_oam(input int mode, output int bad);
    logic [7:0] e;
    bad = 0;
    for (int i = 0; i < 160; i++) begin
      e = (mode == 0) ? (8'(i) ^ 8'h5A) : ~8'(i);
      if (mem[16'hFE00 + 16'(i)] !== e) bad++;
    end
  endtask

  typedef struct {
    logic [7:0]  wdata;
    int          cyc;
    logic [15:0] raddr;
    logic        busy;
    logic        wen;
    logic [15:0] waddr;
    logic [7:0]  wdat;
    logic        done;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int nb, nw, nd, dcyc, first, brk, bad;
    vecs[0]  = '{8'hC0,   0, 16'h0000, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0};
    vecs[1]  = '{8'hC0,   3, 16'h0000, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0};
    vecs[2]  = '{8'hC0,   4, 16'hC000, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0};
    vecs[3]  = '{8'hC0,   5, 16'h0000, 1'b1, 1'b1, 16'hFE00, 8'h5A, 1'b0};
    vecs[4]  = '{8'hC0,   6, 16'h0000, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0};
    vecs[5]  = '{8'hC0,   8, 16'hC001, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0};
    vecs[6]  = '{8'hC0,   9, 16'h0000, 1'b1, 1'b1, 16'hFE01, 8'h5B, 1'b0};
    vecs[7]  = '{8'hC0, 641, 16'h0000, 1'b1, 1'b1, 16'hFE9F, 8'hC5, 1'b0};
    vecs[8]  = '{8'hC0, 644, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1};
    vecs[9]  = '{8'hC0, 645, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0};
    vecs[10] = '{8'h12,   5, 16'h0000, 1'b1, 1'b1, 16'hFE00, 8'h00, 1'b0};

    for (int i = 0; i < 65536; i++) begin
      mem[i]  = 8'h00;
      mem2[i] = 8'h00;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Test 1: reset asserted mid-idle with random inputs
    #2 rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      reg_wen   = 1'($urandom);
      reg_wdata = 8'($urandom);
      #1;
      check("reset_outputs",
            {reg_rdata, mem_r_addr, mem_w_addr, mem_w_data, mem_wen, busy, done}, 64'h0);
    end
    @(negedge clk); reg_wen = 1'b0; rst = 1'b0;

    // Table-driven vectors against a preloaded C0 page
    fill(16'hC000, 160, 0);
    fill(16'h1200, 4, 2);
    for (int v = 0; v < 11; v++) begin
      do_reset();
      write_reg(vecs[v].wdata);
      repeat (vecs[v].cyc) @(negedge clk);
      check($sformatf("vec%0d", v),
            {mem_r_addr, busy, mem_wen, mem_w_addr, mem_w_data, done, reg_rdata},
            {vecs[v].raddr, vecs[v].busy, vecs[v].wen, vecs[v].waddr, vecs[v].wdat,
             vecs[v].done, vecs[v].wdata});
    end

    // Test 2: full default transfer
    do_reset();
    fill(16'hFE00, 160, 2);
    write_reg(8'hC0);
    nb = 0; nw = 0; nd = 0; dcyc = -1; first = -1;
    for (int c = 0; c < 700; c++) begin
      if (busy) nb++;
      if (mem_wen) nw++;
      if (done) begin nd++; dcyc = c; end
      if (mem_r_addr != 16'h0 && first < 0) first = c;
      @(negedge clk);
    end
    check("t2_busy_cycles", 64'(nb), 64'd644);
    check("t2_wen_cycles", 64'(nw), 64'd160);
    check("t2_done_count", 64'(nd), 64'd1);
    check("t2_done_cycle", 64'(dcyc), 64'd644);
    check("t2_first_read", 64'(first), 64'd4);
    count_bad_oam(0, bad);
    check("t2_oam_bad_bytes", 64'(bad), 64'd0);

    // Test 3: restart at cycle 100 with a new source page
    fill(16'hFE00, 160, 2);
    fill(16'hD000, 160, 1);
    write_reg(8'hC0);
    brk = 0; nd = 0;
    for (int c = 0; c < 100; c++) begin
      if (!busy) brk++;
      if (done) nd++;
      @(negedge clk);
    end
    write_reg(8'hD0);
    nb = 0; dcyc = -1;
    for (int c = 0; c < 700; c++) begin
      if (busy) nb++;
      if (c < 644 && !busy) brk++;
      if (done) begin nd++; dcyc = c; end
      @(negedge clk);
    end
    check("t3_busy_gap", 64'(brk), 64'd0);
    check("t3_busy_cycles", 64'(nb), 64'd644);
    check("t3_done_count", 64'(nd), 64'd1);
    check("t3_done_cycle", 64'(dcyc), 64'd644);
    count_bad_oam(1, bad);
    check("t3_oam_bad_bytes", 64'(bad), 64'd0);

    // Test 4: reset during the WRITE of byte 74
    fill(16'hFE00, 160, 2);
    write_reg(8'hC0);
    repeat (301) @(negedge clk);
    check("t4_pre_reset_write", {mem_wen, mem_w_addr}, {1'b1, 16'hFE4A});
    #1 rst = 1'b1;
    #1 check("t4_async_drop", {busy, mem_wen}, 2'b00);
    @(negedge clk); rst = 1'b0;
    repeat (10) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 160; i++) begin
      if (i < 74) begin
        if (mem[16'hFE00 + 16'(i)] !== (8'(i) ^ 8'h5A)) bad++;
      end else if (mem[16'hFE00 + 16'(i)] !== 8'h00) bad++;
    end
    check("t4_partial_bytes", 64'(bad), 64'd0);
    check("t4_idle_after", {busy, done}, 2'b00);

    // Test 5: echo page source address
    do_reset();
    write_reg(8'hE1);
    repeat (4) @(negedge clk);
`ifdef OAM_DMA_ECHO_FOLD_EN
    check("t5_first_raddr", mem_r_addr, 16'hC100);
`else
    check("t5_first_raddr", mem_r_addr, 16'hE100);
`endif
    check("t5_reg_rdata", reg_rdata, 8'hE1);
    do_reset();

    // Test 6: single byte, two-clock slot
    @(negedge clk); pre2_we = 1'b1; pre_addr = 16'h8000; pre_data = 8'hA7;
    @(negedge clk); pre2_we = 1'b0;
    @(negedge clk); s2_wen = 1'b1; s2_wdata = 8'h80;
    @(negedge clk); s2_wen = 1'b0;
    nb = 0; nw = 0; nd = 0; first = -1;
    for (int c = 0; c < 20; c++) begin
      if (s2_busy) nb++;
      if (s2_mwen) begin nw++; first = int'(s2_w_addr); end
      if (s2_done) nd++;
      @(negedge clk);
    end
    check("t6_busy_cycles", 64'(nb), 64'd6);
    check("t6_wen_cycles", 64'(nw), 64'd1);
    check("t6_write_addr", 64'(first), 64'hFE00);
    check("t6_done_count", 64'(nd), 64'd1);
    check("t6_dest_byte", mem2[16'hFE00], 8'hA7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
